fp_div_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one iterative floating-point divider among N_REQ requesters. Accepts one request at a time over valid/ready and holds the operands stable for the divider's whole run. It issues the single-cycle start pulse, detects completion on the divider's level-style done, and returns the result to the granted requester over a valid/ready response channel. It sits between the FPU issue logic and the divider instance.

---
 rtl/fp_div_arbiter.sv | 141 ++++++++++++++
 tb/tb_fp_div_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter and sequencer sharing one iterative FP divider among N_REQ requesters.
// Optional divider watchdog is enabled by defining FP_DIV_ARB_TIMEOUT_EN.
module fp_div_arbiter #(
  parameter int DATA_W  = 32,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_op_a,
  input  logic [N_REQ*DATA_W-1:0] req_op_b,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_res,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    div_start,
  output logic [DATA_W-1:0]       div_op_a,
  output logic [DATA_W-1:0]       div_op_b,
  input  logic                    div_done,
  input  logic [DATA_W-1:0]       div_res
);
  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : g_param_check
    $error("fp_div_arbiter: N_REQ must be 2..16 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx;
  logic             pick_ok;

`ifdef FP_DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    pick    = last;
    pick_ok = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last) + k) % N_REQ);
      if (!pick_ok && req_valid[idx]) begin
        pick_ok = 1'b1;
        pick    = idx;
      end
    end
  end

  // Handshakes: a request transfers in the IDLE cycle where req_valid[i] and req_ready[i]
  // are both high (requesters hold valid until then); a response transfers in the cycle
  // where rsp_valid[g] and rsp_ready[g] are both high.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && pick_ok) req_ready[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDX_W'(N_REQ - 1);
      cur       <= '0;
      div_op_a  <= '0;
      div_op_b  <= '0;
      div_start <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= '0;
      rsp_res   <= '0;
`ifdef FP_DIV_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_ok) begin
            cur       <= pick;
            last      <= pick;
            div_op_a  <= req_op_a[int'(pick)*DATA_W +: DATA_W];
            div_op_b  <= req_op_b[int'(pick)*DATA_W +: DATA_W];
            div_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // div_done may still be high from the previous operation; never look at it here.
          div_start <= 1'b0;
          state     <= WAIT;
`ifdef FP_DIV_ARB_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        WAIT: begin
          if (div_done) begin
            rsp_res        <= div_res;
            rsp_valid      <= '0;
            rsp_valid[cur] <= 1'b1;
            state          <= RESP;
`ifdef FP_DIV_ARB_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
          end
`ifdef FP_DIV_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_res        <= QNAN;
            err_q          <= 1'b1;
            rsp_valid      <= '0;
            rsp_valid[cur] <= 1'b1;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready[cur]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model; timeout scenario built when FP_DIV_ARB_TIMEOUT_EN is set.
module tb_fp_div_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 20;
  localparam logic [W-1:0] QNAN = 32'h7FC0_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_op_a = '0;
  logic [N*W-1:0] req_op_b = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [W-1:0]   rsp_res;
  logic           rsp_err;
  logic           busy;
  logic           div_start;
  logic [W-1:0]   div_op_a;
  logic [W-1:0]   div_op_b;
  logic           div_done = 1'b0;
  logic [W-1:0]   div_res = '0;

  fp_div_arbiter #(.DATA_W(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_err(rsp_err), .busy(busy),
    .div_start(div_start), .div_op_a(div_op_a), .div_op_b(div_op_b),
    .div_done(div_done), .div_res(div_res)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] div_fn(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h3F00_0000;
    if (a == 32'h40C0_0000 && b == 32'h4040_0000) return 32'h4000_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int first_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- divider model (level-style done, stays high while idle) ----------------
  int           dv_lat = 3;
  int           dv_cnt = 0;
  logic         dv_go;
  logic [W-1:0] dv_a, dv_b;
  initial forever begin
    @(negedge clk);
    dv_go = div_start; dv_a = div_op_a; dv_b = div_op_b;
    @(posedge clk); #1;
    if (dv_go) begin
      dv_cnt   = (dv_lat < 0) ? int'($urandom_range(1, 15)) : dv_lat;
      div_done = 1'b0;
      div_res  = div_fn(dv_a, dv_b);
    end else if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) div_done = 1'b1;
    end
  end

  // ---------------- reference model + logs ----------------
  bit           m_busy = 0;
  int           m_t = 0, m_d = -1, m_g = 0, m_last = N - 1;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic         m_err = 1'b0;
  logic [N-1:0] prev_rv = '0;
  logic [W-1:0] exp_q[$];
  int           grant_q[$], grant_t[$], start_t[$], rise_t[$], rsp_idx_q[$];
  logic [W-1:0] rsp_res_q[$];
  logic         rsp_err_q[$];

  task automatic clear_logs();
    grant_q.delete(); grant_t.delete(); start_t.delete(); rise_t.delete();
    rsp_idx_q.delete(); rsp_res_q.delete(); rsp_err_q.delete();
  endtask

  always @(negedge clk) begin
    logic [N-1:0] e_rdy, e_rv;
    int pick;
    if (!rst_n) begin
      m_busy = 0; m_last = N - 1; m_d = -1; m_a = '0; m_b = '0; m_err = 1'b0;
      prev_rv = '0;
      exp_q.delete();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_res", rsp_res, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_div_op_a", div_op_a, 0);
      chk("rst_div_op_b", div_op_b, 0);
    end else begin
      e_rdy = '0; e_rv = '0; pick = -1;
      if (!m_busy) begin
        pick = rr_pick(req_valid, m_last);
        if (pick >= 0) e_rdy[pick] = 1'b1;
      end else if (m_d >= 0) begin
        e_rv[m_g] = 1'b1;
      end
      chk("req_ready", req_ready, e_rdy);
      chk("busy", busy, m_busy);
      chk("div_start", div_start, m_busy && cyc == m_t + 1);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("div_op_a", div_op_a, m_a);
      chk("div_op_b", div_op_b, m_b);
      if (m_busy && m_d >= 0) begin
        chk("rsp_res", rsp_res, m_res);
        chk("rsp_err", rsp_err, m_err);
      end
      // logs for directed checks
      if (req_ready != 0) begin grant_q.push_back(first_idx(req_ready)); grant_t.push_back(cyc); end
      if (div_start) start_t.push_back(cyc);
      if (rsp_valid != 0 && prev_rv == 0) rise_t.push_back(cyc);
      if ((rsp_valid & rsp_ready) != 0) begin
        rsp_idx_q.push_back(first_idx(rsp_valid));
        rsp_res_q.push_back(rsp_res);
        rsp_err_q.push_back(rsp_err);
        if (exp_q.size() > 0) chk("rsp_hs_res", rsp_res, exp_q.pop_front());
        else chk("rsp_unexpected", rsp_valid, 0);
      end
      prev_rv = rsp_valid;
      // advance the transaction model
      if (!m_busy) begin
        if (pick >= 0) begin
          m_busy = 1; m_t = cyc; m_g = pick; m_last = pick; m_d = -1;
          m_a = req_op_a[pick*W +: W];
          m_b = req_op_b[pick*W +: W];
        end
      end else if (m_d < 0) begin
        if (cyc >= m_t + 2 && div_done) begin
          m_d = cyc; m_res = div_fn(m_a, m_b); m_err = 1'b0; exp_q.push_back(m_res);
        end
`ifdef FP_DIV_ARB_TIMEOUT_EN
        else if (cyc == m_t + 1 + TO) begin
          m_d = cyc; m_res = QNAN; m_err = 1'b1; exp_q.push_back(m_res);
        end
`endif
      end else if (rsp_ready[m_g]) begin
        m_busy = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 0;
    req_op_a[i*W +: W] = a;
    req_op_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); ok = req_ready[i];
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_rsps(input int n, input int max);
    int k;
    k = 0;
    while (rsp_idx_q.size() < n && k < max) begin @(posedge clk); #1; k++; end
    chk("wait_rsp", rsp_idx_q.size() >= n, 1);
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while ((busy || m_busy) && k < max) begin @(posedge clk); #1; k++; end
    chk("wait_idle", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] seen;
    logic         seen_rv;
    int           k;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // round robin from reset: all four requesters valid continuously
    clear_logs(); dv_lat = 3; rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      req_op_a[i*W +: W] = $urandom; req_op_b[i*W +: W] = $urandom;
    end
    req_valid = '1;
    k = 0;
    while (grant_q.size() < 5 && k < 200) begin @(posedge clk); #1; k++; end
    req_valid = '0;
    wait_rsps(5, 100);
    for (int j = 0; j < 5; j++) begin
      chk("rr_order", grant_q[j], j % N);
      chk("rr_rsp_idx", rsp_idx_q[j], j % N);
    end

    // single request from requester 1: 1.0 / 2.0
    wait_idle(50);
    clear_logs(); dv_lat = 10;
    send(1, 32'h3F80_0000, 32'h4000_0000);
    wait_rsps(1, 60);
    chk("single_grant", grant_q[0], 1);
    chk("single_start_lat", start_t[0] - grant_t[0], 1);
    chk("single_rsp_lat", rise_t[0] - grant_t[0], 13);
    chk("single_rsp_idx", rsp_idx_q[0], 1);
    chk("single_res", rsp_res_q[0], 32'h3F00_0000);
    chk("single_err", rsp_err_q[0], 0);

    // stale done: divider still signalling done from the previous operation
    wait_idle(50);
    clear_logs(); dv_lat = 4;
    chk("stale_done_pre", div_done, 1);
    send(3, 32'h40C0_0000, 32'h4040_0000);
    wait_rsps(1, 60);
    chk("stale_rsp_lat", rise_t[0] - grant_t[0], 7);
    chk("stale_res", rsp_res_q[0], 32'h4000_0000);

    // backpressure on requester 2 while requester 0 waits
    wait_idle(50);
    clear_logs(); dv_lat = 2; rsp_ready = 4'b1011;
    send(2, 32'h4120_0000, 32'h4080_0000);
    req_op_a[0 +: W] = 32'h3F80_0000; req_op_b[0 +: W] = 32'h3F80_0000; req_valid[0] = 1'b1;
    seen_rv = 1'b0; k = 0;
    while (!seen_rv && k < 50) begin @(negedge clk); seen_rv = rsp_valid[2]; k++; end
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 4'b0100);
      chk("bp_rsp_res", rsp_res, div_fn(32'h4120_0000, 32'h4080_0000));
      chk("bp_busy", busy, 1);
      chk("bp_no_grant", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle", busy, 0);
    chk("bp_next_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_rsps(2, 60);

    // reset while waiting on a hung divider
    wait_idle(50);
    rsp_ready = '1; dv_lat = 100000;
    send(3, 32'h1234_5678, 32'h0BAD_F00D);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; req_valid = 4'b0101; dv_lat = 5; clear_logs();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_next_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_rsps(1, 60);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_rsp_count", rsp_idx_q.size(), 1);
    chk("rst_rsp_idx", rsp_idx_q[0], 0);

    // randomized traffic with occasional reset pulses
    dv_lat = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); seen = req_ready;
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && seen[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_op_a[i*W +: W] = $urandom;
          req_op_b[i*W +: W] = $urandom;
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
    end
    rst_n = 1'b1; req_valid = '0; rsp_ready = '1;
    wait_idle(100);

`ifdef FP_DIV_ARB_TIMEOUT_EN
    clear_logs(); dv_lat = 100000;
    send(1, 32'h3F80_0000, 32'h0000_0000);
    wait_rsps(1, 80);
    chk("to_rsp_lat", rise_t[0] - grant_t[0], 2 + TO);
    chk("to_res", rsp_res_q[0], QNAN);
    chk("to_err", rsp_err_q[0], 1);
    wait_idle(20);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
